// File: rtl/gba_cpu_pkg.sv
// Shared types and constants for the ARM7TDMI exception entry logic.
package gba_cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MODE_W  = 5;
  localparam int unsigned NUM_EXC = 6;
  localparam int unsigned REG_W   = 4;

  localparam int unsigned CPSR_I = 7;
  localparam int unsigned CPSR_F = 6;
  localparam int unsigned CPSR_T = 5;

  // Exception ids match the bit positions of exc_req/exc_ack
  typedef enum logic [2:0] {
    EXC_SWI  = 3'd0,
    EXC_UND  = 3'd1,
    EXC_PABT = 3'd2,
    EXC_IRQ  = 3'd3,
    EXC_FIQ  = 3'd4,
    EXC_DABT = 3'd5
  } exc_e;

  localparam logic [MODE_W-1:0] MODE_FIQ = 5'b10001;
  localparam logic [MODE_W-1:0] MODE_IRQ = 5'b10010;
  localparam logic [MODE_W-1:0] MODE_SVC = 5'b10011;
  localparam logic [MODE_W-1:0] MODE_ABT = 5'b10111;
  localparam logic [MODE_W-1:0] MODE_UND = 5'b11011;

  localparam logic [7:0] VEC_UND  = 8'h04;
  localparam logic [7:0] VEC_SWI  = 8'h08;
  localparam logic [7:0] VEC_PABT = 8'h0C;
  localparam logic [7:0] VEC_DABT = 8'h10;
  localparam logic [7:0] VEC_IRQ  = 8'h18;
  localparam logic [7:0] VEC_FIQ  = 8'h1C;

  // SVC mode, IRQ and FIQ disabled, ARM state
  localparam logic [XLEN-1:0] BOOT_CPSR_VAL = {24'h0, 1'b1, 1'b1, 1'b0, MODE_SVC};

  localparam logic [REG_W-1:0] REG_LR = 4'd14;
  localparam logic [REG_W-1:0] REG_PC = 4'd15;

  typedef enum logic [2:0] {
    ST_BOOT_CPSR  = 3'd0,
    ST_BOOT_PC    = 3'd1,
    ST_IDLE       = 3'd2,
    ST_WRITE_CPSR = 3'd3,
    ST_WRITE_LR   = 3'd4,
    ST_LOAD_PC    = 3'd5
  } state_e;

  function automatic logic [MODE_W-1:0] exc_mode(input exc_e e);
    case (e)
      EXC_DABT, EXC_PABT: return MODE_ABT;
      EXC_FIQ:            return MODE_FIQ;
      EXC_IRQ:            return MODE_IRQ;
      EXC_UND:            return MODE_UND;
      default:            return MODE_SVC;
    endcase
  endfunction

  function automatic logic [7:0] exc_vector(input exc_e e);
    case (e)
      EXC_DABT: return VEC_DABT;
      EXC_FIQ:  return VEC_FIQ;
      EXC_IRQ:  return VEC_IRQ;
      EXC_PABT: return VEC_PABT;
      EXC_UND:  return VEC_UND;
      default:  return VEC_SWI;
    endcase
  endfunction

endpackage

// File: rtl/exception_priority_encoder.sv
// Fixed-priority pick of the highest pending exception: DABT > FIQ > IRQ > PABT > UND > SWI.
module exception_priority_encoder
  import gba_cpu_pkg::*;
(
  input  logic [NUM_EXC-1:0] i_req,
  output logic [NUM_EXC-1:0] o_onehot,
  output exc_e               o_exc,
  output logic               o_valid
);

  // Scan upward so the highest set bit overrides lower ones
  always_comb begin
    o_onehot = '0;
    o_exc    = EXC_SWI;
    o_valid  = |i_req;
    for (int i = 0; i < NUM_EXC; i++) begin
      if (i_req[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_exc       = exc_e'(3'(i));
      end
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Boot and exception-entry sequencer driving the register file write port, one write per cycle.
module exception_sequencer
  import gba_cpu_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_EXC-1:0]  exc_req,
  input  logic                instr_boundary,
  input  logic [XLEN-1:0]     cpsr_in,
  input  logic [XLEN-1:0]     pc_in,
  output logic                busy,
  output logic                flush,
  output logic [NUM_EXC-1:0]  exc_ack,
  output logic                gpr_write,
  output logic [REG_W-1:0]    gpr_write_sel,
  output logic [XLEN-1:0]     gpr_write_data,
  output logic                cpsr_write,
  output logic [XLEN-1:0]     cpsr_data,
  output logic                spsr_write,
  output logic [MODE_W-1:0]   spsr_mode,
  output logic [XLEN-1:0]     spsr_data
);

  state_e               r_state;
  exc_e                 r_exc;
  logic [NUM_EXC-1:0]   r_onehot;
  logic [XLEN-1:0]      r_cpsr;
  logic [XLEN-1:0]      r_pc;

  state_e               w_next_state;
  logic [NUM_EXC-1:0]   w_masked;
  logic [NUM_EXC-1:0]   w_win_onehot;
  exc_e                 w_win_exc;
  logic                 w_win_valid;
  logic                 w_latch;
  logic                 w_busy;
  logic [NUM_EXC-1:0]   w_ack;
  logic                 w_gpr_write;
  logic [REG_W-1:0]     w_gpr_sel;
  logic [XLEN-1:0]      w_gpr_data;
  logic                 w_cpsr_write;
  logic [XLEN-1:0]      w_cpsr_data;
  logic                 w_spsr_write;
  logic [MODE_W-1:0]    w_spsr_mode;
  logic [XLEN-1:0]      w_spsr_data;

  function automatic logic [XLEN-1:0] lr_offset(input exc_e e, input logic thumb);
    if (!thumb) return (e == EXC_DABT) ? 32'd0 : 32'hFFFF_FFFC;
    case (e)
      EXC_DABT:         return 32'd4;
      EXC_SWI, EXC_UND: return 32'hFFFF_FFFE;
      default:          return 32'd0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] entry_cpsr(input logic [XLEN-1:0] old, input exc_e e);
    logic [XLEN-1:0] c;
    c          = old;
    c[4:0]     = exc_mode(e);
    c[CPSR_T]  = 1'b0;
    c[CPSR_I]  = 1'b1;
    if (e == EXC_FIQ) c[CPSR_F] = 1'b1;
    return c;
  endfunction

  assign w_masked = exc_req & ~{1'b0, cpsr_in[CPSR_F], cpsr_in[CPSR_I], 3'b000};

  exception_priority_encoder u_prio (
    .i_req    (w_masked),
    .o_onehot (w_win_onehot),
    .o_exc    (w_win_exc),
    .o_valid  (w_win_valid)
  );

  // The SPSR save is issued on the accept edge itself, so IDLE hands off straight to WRITE_CPSR
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_busy       = 1'b1;
    w_ack        = '0;
    w_gpr_write  = 1'b0;
    w_gpr_sel    = '0;
    w_gpr_data   = '0;
    w_cpsr_write = 1'b0;
    w_cpsr_data  = '0;
    w_spsr_write = 1'b0;
    w_spsr_mode  = '0;
    w_spsr_data  = '0;
    case (r_state)
      ST_BOOT_CPSR: begin
        w_cpsr_write = 1'b1;
        w_cpsr_data  = BOOT_CPSR_VAL;
        w_next_state = ST_BOOT_PC;
      end
      ST_BOOT_PC: begin
        w_gpr_write  = 1'b1;
        w_gpr_sel    = REG_PC;
        w_gpr_data   = VECTOR_BASE;
        w_next_state = ST_IDLE;
      end
      ST_IDLE: begin
        w_busy = 1'b0;
        if (instr_boundary && w_win_valid) begin
          w_latch      = 1'b1;
          w_busy       = 1'b1;
          w_spsr_write = 1'b1;
          w_spsr_mode  = exc_mode(w_win_exc);
          w_spsr_data  = cpsr_in;
          w_next_state = ST_WRITE_CPSR;
        end
      end
      ST_WRITE_CPSR: begin
        w_cpsr_write = 1'b1;
        w_cpsr_data  = entry_cpsr(r_cpsr, r_exc);
        w_next_state = ST_WRITE_LR;
      end
      ST_WRITE_LR: begin
        w_gpr_write  = 1'b1;
        w_gpr_sel    = REG_LR;
        w_gpr_data   = r_pc + lr_offset(r_exc, r_cpsr[CPSR_T]);
        w_next_state = ST_LOAD_PC;
      end
      ST_LOAD_PC: begin
        w_gpr_write  = 1'b1;
        w_gpr_sel    = REG_PC;
        w_gpr_data   = VECTOR_BASE + 32'(exc_vector(r_exc));
        w_ack        = r_onehot;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_BOOT_CPSR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_BOOT_CPSR;
    else          r_state <= w_next_state;
  end

  // Winner and context captured at acceptance; later input changes cannot disturb the entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exc    <= EXC_SWI;
      r_onehot <= '0;
      r_cpsr   <= '0;
      r_pc     <= '0;
    end else if (w_latch) begin
      r_exc    <= w_win_exc;
      r_onehot <= w_win_onehot;
      r_cpsr   <= cpsr_in;
      r_pc     <= pc_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy           <= 1'b1;
      exc_ack        <= '0;
      gpr_write      <= 1'b0;
      gpr_write_sel  <= '0;
      gpr_write_data <= '0;
      cpsr_write     <= 1'b0;
      cpsr_data      <= '0;
      spsr_write     <= 1'b0;
      spsr_mode      <= '0;
      spsr_data      <= '0;
    end else begin
      busy           <= w_busy;
      exc_ack        <= w_ack;
      gpr_write      <= w_gpr_write;
      gpr_write_sel  <= w_gpr_sel;
      gpr_write_data <= w_gpr_data;
      cpsr_write     <= w_cpsr_write;
      cpsr_data      <= w_cpsr_data;
      spsr_write     <= w_spsr_write;
      spsr_mode      <= w_spsr_mode;
      spsr_data      <= w_spsr_data;
    end
  end

  assign flush = busy;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: boot, table of entries, masking and mid-sequence reset.
module tb_exception_sequencer;

  logic        clk;
  logic        reset_n;
  logic [5:0]  exc_req;
  logic        instr_boundary;
  logic [31:0] cpsr_in;
  logic [31:0] pc_in;
  logic        busy;
  logic        flush;
  logic [5:0]  exc_ack;
  logic        gpr_write;
  logic [3:0]  gpr_write_sel;
  logic [31:0] gpr_write_data;
  logic        cpsr_write;
  logic [31:0] cpsr_data;
  logic        spsr_write;
  logic [4:0]  spsr_mode;
  logic [31:0] spsr_data;

  int n_checks = 0;
  int n_fail   = 0;

  exception_sequencer #(.VECTOR_BASE(32'h0000_0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .exc_req        (exc_req),
    .instr_boundary (instr_boundary),
    .cpsr_in        (cpsr_in),
    .pc_in          (pc_in),
    .busy           (busy),
    .flush          (flush),
    .exc_ack        (exc_ack),
    .gpr_write      (gpr_write),
    .gpr_write_sel  (gpr_write_sel),
    .gpr_write_data (gpr_write_data),
    .cpsr_write     (cpsr_write),
    .cpsr_data      (cpsr_data),
    .spsr_write     (spsr_write),
    .spsr_mode      (spsr_mode),
    .spsr_data      (spsr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  req;
    logic [31:0] cpsr;
    logic [31:0] pc;
    logic [4:0]  mode;
    logic [31:0] ecpsr;
    logic [31:0] elr;
    logic [31:0] epc;
    logic [5:0]  ack;
  } vec_t;

  vec_t vecs[9];
  vec_t v2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Covers cycles N+1..N+4 after an accepting edge; optionally re-arms instr_boundary while busy
  task automatic expect_entry(input vec_t v, input logic [5:0] hreq, input logic [31:0] hcpsr,
                              input logic [31:0] hpc, input bit rearm);
    tick();
    exc_req = hreq; cpsr_in = hcpsr; pc_in = hpc; instr_boundary = 1'b0;
    chk("spsr_busy", busy, 1);
    chk("spsr_write", spsr_write, 1);
    chk("spsr_mode", spsr_mode, v.mode);
    chk("spsr_data", spsr_data, v.cpsr);
    chk("spsr_only_cpsr", cpsr_write, 0);
    chk("spsr_only_gpr", gpr_write, 0);
    tick();
    chk("cpsr_write", cpsr_write, 1);
    chk("cpsr_data", cpsr_data, v.ecpsr);
    chk("cpsr_only_spsr", spsr_write, 0);
    chk("cpsr_only_gpr", gpr_write, 0);
    tick();
    chk("lr_write", gpr_write, 1);
    chk("lr_sel", gpr_write_sel, 14);
    chk("lr_data", gpr_write_data, v.elr);
    chk("lr_only_cpsr", cpsr_write, 0);
    if (rearm) instr_boundary = 1'b1;
    tick();
    chk("pc_write", gpr_write, 1);
    chk("pc_sel", gpr_write_sel, 15);
    chk("pc_data", gpr_write_data, v.epc);
    chk("pc_ack", exc_ack, v.ack);
    chk("pc_flush", flush, 1);
  endtask

  task automatic expect_idle(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_flush"}, flush, 0);
    chk({nm, "_ack"}, exc_ack, 0);
    chk({nm, "_spsr"}, spsr_write, 0);
  endtask

  task automatic expect_boot();
    tick();
    chk("boot_cpsr_write", cpsr_write, 1);
    chk("boot_cpsr_data", cpsr_data, 32'hD3);
    chk("boot_cpsr_gpr", gpr_write, 0);
    chk("boot_cpsr_busy", busy, 1);
    tick();
    chk("boot_pc_write", gpr_write, 1);
    chk("boot_pc_sel", gpr_write_sel, 15);
    chk("boot_pc_data", gpr_write_data, 32'h0);
    chk("boot_pc_cpsr", cpsr_write, 0);
    tick();
    expect_idle("boot_done");
  endtask

  initial begin
    //            req        cpsr          pc            mode      ecpsr         elr           epc     ack
    vecs[0] = '{6'b001000, 32'h10,       32'h108,      5'b10010, 32'h92,       32'h104,      32'h18, 6'b001000};
    vecs[1] = '{6'b111000, 32'h10,       32'h208,      5'b10111, 32'h97,       32'h208,      32'h10, 6'b100000};
    vecs[2] = '{6'b000001, 32'h30,       32'h2004,     5'b10011, 32'h93,       32'h2002,     32'h08, 6'b000001};
    vecs[3] = '{6'b010000, 32'h1F,       32'h400,      5'b10001, 32'hD1,       32'h3FC,      32'h1C, 6'b010000};
    vecs[4] = '{6'b000010, 32'h30,       32'h3000,     5'b11011, 32'h9B,       32'h2FFE,     32'h04, 6'b000010};
    vecs[5] = '{6'b100000, 32'hF000_0030, 32'h500,     5'b10111, 32'hF000_0097, 32'h504,     32'h10, 6'b100000};
    vecs[6] = '{6'b000100, 32'h5F,       32'h0,        5'b10111, 32'hD7,       32'hFFFF_FFFC, 32'h0C, 6'b000100};
    vecs[7] = '{6'b001000, 32'h2000_0030, 32'h800,     5'b10010, 32'h2000_0092, 32'h800,     32'h18, 6'b001000};
    vecs[8] = '{6'b000011, 32'h13,       32'h100,      5'b11011, 32'h9B,       32'hFC,       32'h04, 6'b000010};

    reset_n = 1'b0; exc_req = '0; instr_boundary = 1'b0; cpsr_in = '0; pc_in = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 1);
    chk("rst_flush", flush, 1);
    chk("rst_cpsr_write", cpsr_write, 0);
    chk("rst_gpr_write", gpr_write, 0);
    chk("rst_gpr_data", gpr_write_data, 0);
    chk("rst_cpsr_data", cpsr_data, 0);
    chk("rst_ack", exc_ack, 0);
    chk("rst_spsr_write", spsr_write, 0);
    reset_n = 1'b1;
    expect_boot();

    for (int i = 0; i < 9; i++) begin
      exc_req = vecs[i].req; cpsr_in = vecs[i].cpsr; pc_in = vecs[i].pc; instr_boundary = 1'b1;
      expect_entry(vecs[i], 6'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
      tick();
      expect_idle("vec_after");
    end

    // Masked IRQ (I=1), masked FIQ (F=1), request without boundary, then a dropped request
    exc_req = 6'b001000; cpsr_in = 32'h90; instr_boundary = 1'b1;
    repeat (4) begin tick(); expect_idle("irq_masked"); end
    exc_req = 6'b010000; cpsr_in = 32'h50;
    repeat (4) begin tick(); expect_idle("fiq_masked"); end
    exc_req = 6'b000001; cpsr_in = 32'h10; instr_boundary = 1'b0;
    repeat (3) begin tick(); expect_idle("no_boundary"); end
    exc_req = 6'b0; instr_boundary = 1'b1;
    repeat (2) begin tick(); expect_idle("dropped"); end

    // DABT beats FIQ/IRQ; FIQ (still asserted) is taken on the very next pass
    exc_req = 6'b111000; cpsr_in = 32'h10; pc_in = 32'h208; instr_boundary = 1'b1;
    expect_entry(vecs[1], 6'b011000, 32'h97, 32'h18, 1'b1);
    v2 = '{6'b0, 32'h97, 32'h18, 5'b10001, 32'hD1, 32'h14, 32'h1C, 6'b010000};
    expect_entry(v2, 6'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expect_idle("fiq_next_done");

    // Reset while the LR write is pending abandons the entry
    exc_req = 6'b001000; cpsr_in = 32'h10; pc_in = 32'h108; instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    chk("mid_spsr_write", spsr_write, 1);
    tick();
    chk("mid_cpsr_write", cpsr_write, 1);
    chk("mid_cpsr_data", cpsr_data, 32'h92);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_gpr", gpr_write, 0);
    chk("mid_rst_gpr_data", gpr_write_data, 0);
    repeat (2) begin
      tick();
      chk("mid_rst_hold_gpr", gpr_write, 0);
      chk("mid_rst_hold_ack", exc_ack, 0);
    end
    reset_n = 1'b1;
    expect_boot();
    repeat (3) begin tick(); expect_idle("post_boot_blocked"); end
    instr_boundary = 1'b1;
    expect_entry(vecs[0], 6'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expect_idle("post_boot_entry_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
